// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point adder result stage.
`timescale 1ns/1ps
package fp_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    // Bit positions inside the {guard, round, sticky} triple.
    localparam int unsigned GRS_G = 2;
    localparam int unsigned GRS_R = 1;
    localparam int unsigned GRS_S = 0;

    typedef enum logic [1:0] {
        StIdle,
        StNorm,
        StRound,
        StOut
    } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of a normalized mantissa using guard/round/sticky.
`timescale 1ns/1ps
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int unsigned FRAC_W = fp_pkg::FRAC_W
) (
    input  logic [FRAC_W+1:0] m,
    input  logic [2:0]        grs,
    output logic [FRAC_W+1:0] m_rounded,
    output logic              carry,
    output logic              inexact
);

    logic round_up;

    always_comb begin
        round_up  = grs[GRS_G] & (grs[GRS_R] | grs[GRS_S] | m[0]);
        m_rounded = m + {{(FRAC_W+1){1'b0}}, round_up};
        carry     = m_rounded[FRAC_W+1];
        inexact   = |grs;
    end

endmodule

// File: rtl/fp_result_packer.sv
// Normalizes, rounds (RNE) and packs an unnormalized adder sum into an IEEE-754 word.
`timescale 1ns/1ps
module fp_result_packer #(
    parameter int unsigned EXP_W  = fp_pkg::EXP_W,
    parameter int unsigned FRAC_W = fp_pkg::FRAC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exponent,
    input  logic [FRAC_W+1:0]       in_mantissa,
    input  logic [2:0]              in_grs,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out,
    output logic                    out_overflow,
    output logic                    out_inexact,
    output logic                    out_underflow
);
    import fp_pkg::*;

    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned MW = FRAC_W + 2;
    localparam int unsigned W  = 1 + EXP_W + FRAC_W;
    localparam logic [EW-1:0] E_SAT = {2'b00, {EXP_W{1'b1}}};

    state_t          state_q;
    logic            sign_q;
    logic [EW-1:0]   exp_q;
    logic [MW-1:0]   mant_q;
    logic [2:0]      grs_q;

    logic [MW-1:0]   mant_rnd;
    logic            rnd_carry;
    logic            rnd_inexact;
    logic [FRAC_W:0] mant_post;
    logic [EW-1:0]   exp_post;
    logic            rnd_overflow;
    logic            rnd_underflow;
    logic [W-1:0]    rnd_word;

    assign in_ready = (state_q == StIdle) && !reset;

    fp_round_rne #(
        .FRAC_W(FRAC_W)
    ) u_round (
        .m         (mant_q),
        .grs       (grs_q),
        .m_rounded (mant_rnd),
        .carry     (rnd_carry),
        .inexact   (rnd_inexact)
    );

    always_comb begin
        mant_post = rnd_carry ? mant_rnd[MW-1:1] : mant_rnd[FRAC_W:0];
        exp_post  = rnd_carry ? exp_q + EW'(1) : exp_q;
        // A subnormal that rounds up into the hidden bit becomes the smallest normal.
        if (exp_post == '0 && mant_post[FRAC_W]) begin
            exp_post = EW'(1);
        end
        rnd_overflow = exp_post >= E_SAT;
        if (rnd_overflow) begin
            rnd_word = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            rnd_word = {sign_q, exp_post[EXP_W-1:0], mant_post[FRAC_W-1:0]};
        end
        rnd_underflow = !rnd_overflow && (exp_post == '0) && rnd_inexact;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            sign_q        <= 1'b0;
            exp_q         <= '0;
            mant_q        <= '0;
            grs_q         <= '0;
            out_valid     <= 1'b0;
            out           <= '0;
            out_overflow  <= 1'b0;
            out_inexact   <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sign_q  <= in_sign;
                        exp_q   <= {2'b00, in_exponent};
                        mant_q  <= in_mantissa;
                        grs_q   <= in_grs;
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    if (mant_q == '0 && grs_q == '0) begin
                        exp_q         <= '0;
                        out           <= {sign_q, {(W-1){1'b0}}};
                        out_overflow  <= 1'b0;
                        out_inexact   <= 1'b0;
                        out_underflow <= 1'b0;
                        state_q       <= StOut;
                    end else if (mant_q[FRAC_W+1]) begin
                        mant_q  <= mant_q >> 1;
                        grs_q   <= {mant_q[0], grs_q[GRS_G], grs_q[GRS_R] | grs_q[GRS_S]};
                        exp_q   <= exp_q + EW'(1);
                        state_q <= StRound;
                    end else if (mant_q[FRAC_W]) begin
                        state_q <= StRound;
                    end else if (exp_q <= EW'(1)) begin
                        exp_q   <= '0;
                        state_q <= StRound;
                    end else begin
                        mant_q <= {mant_q[FRAC_W:0], grs_q[GRS_G]};
                        grs_q  <= {grs_q[GRS_R], grs_q[GRS_S], 1'b0};
                        exp_q  <= exp_q - EW'(1);
                    end
                end
                StRound: begin
                    out           <= rnd_word;
                    out_overflow  <= rnd_overflow;
                    out_inexact   <= rnd_inexact;
                    out_underflow <= rnd_underflow;
                    state_q       <= StOut;
                end
                StOut: begin
                    // Result registers settle on entry; valid follows one cycle later.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_result_packer.sv
// Scoreboard bench: directed plan cases plus random sums checked against an arithmetic model.
`timescale 1ns/1ps
module tb_fp_result_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exponent = '0;
    logic [24:0] in_mantissa = '0;
    logic [2:0]  in_grs = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic        out_overflow;
    logic        out_inexact;
    logic        out_underflow;

    fp_result_packer u_dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exponent   (in_exponent),
        .in_mantissa   (in_mantissa),
        .in_grs        (in_grs),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out           (out),
        .out_overflow  (out_overflow),
        .out_inexact   (out_inexact),
        .out_underflow (out_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] word;
        bit          ov;
        bit          inx;
        bit          unf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(logic [31:0] w, bit ov, bit inx, bit unf, int lat);
        exp_t x;
        x.word = w; x.ov = ov; x.inx = inx; x.unf = unf; x.lat = lat; x.acc = 0;
        return x;
    endfunction

    // Value = {m,grs} * 2^(e - bias - 26); normalize so the hidden bit sits at 2^26.
    function automatic exp_t model(bit s, int e, bit [24:0] m, bit [2:0] g);
        exp_t x;
        longint v;
        longint keep;
        longint rem;
        int ee;
        int shifts;
        v = longint'({m, g});
        ee = e;
        shifts = 0;
        x.acc = 0;
        if (v == 0) begin
            x.word = {s, 31'b0}; x.ov = 0; x.inx = 0; x.unf = 0; x.lat = 2;
            return x;
        end
        if (v >= (64'd1 << 27)) begin
            v = (v >> 1) | (v & 1);
            ee++;
        end else if (v < (64'd1 << 26)) begin
            while (v < (64'd1 << 26) && ee > 1) begin
                v = v << 1;
                ee--;
                shifts++;
            end
            if (v < (64'd1 << 26)) ee = 0;
        end
        keep = v >> 3;
        rem = v & 7;
        x.inx = (rem != 0);
        if (rem > 4 || (rem == 4 && keep[0])) keep++;
        if (keep >= (64'd1 << 24)) begin
            keep = keep >> 1;
            ee++;
        end
        if (ee == 0 && keep >= (64'd1 << 23)) ee = 1;
        x.ov = (ee >= 255);
        if (x.ov) x.word = {s, 8'hFF, 23'b0};
        else x.word = {s, ee[7:0], keep[22:0]};
        x.unf = !x.ov && (ee == 0) && x.inx;
        x.lat = 3 + shifts;
        return x;
    endfunction

    task automatic send(bit s, bit [7:0] e, bit [24:0] m, bit [2:0] g, exp_t x);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual in_ready=0 required 1");
            return;
        end
        in_sign = s; in_exponent = e; in_mantissa = m; in_grs = g; in_valid = 1'b1;
        x.acc = cyc + 1;
        q.push_back(x);
        @(negedge clk);
        in_valid = 1'b0;
        in_sign = 1'($urandom); in_exponent = 8'($urandom);
        in_mantissa = 25'($urandom); in_grs = 3'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(q.size() == 0 && in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual pending=%0d required 0", q.size());
        end
    endtask

    // Monitor: pops an expectation on each rising out_valid, then checks it is held.
    initial begin
        exp_t cur;
        bit prev_valid = 1'b0;
        bit prev_ready = 1'b0;
        cur = mk(32'h0, 0, 0, 0, 0);
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (!prev_valid) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output actual %h required none", out);
                    end else begin
                        cur = q.pop_front();
                        check("word", out, cur.word);
                        check("overflow", 32'(out_overflow), 32'(cur.ov));
                        check("inexact", 32'(out_inexact), 32'(cur.inx));
                        check("underflow", 32'(out_underflow), 32'(cur.unf));
                        check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                end else if (prev_ready) begin
                    checks++; errors++;
                    $display("FAIL valid_not_dropped actual out_valid=1 required 0");
                end else begin
                    check("held_word", out, cur.word);
                    check("held_flags", {29'b0, out_overflow, out_inexact, out_underflow},
                          {29'b0, cur.ov, cur.inx, cur.unf});
                end
                check("in_ready_in_out", 32'(in_ready), 32'd0);
            end
            prev_valid = out_valid;
            out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            prev_ready = out_ready;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual time=%0t required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit s;
        bit [7:0] e;
        bit [24:0] m;
        bit [2:0] g;
        logic [31:0] held;

        repeat (2) @(negedge clk);
        check("rst_out", out, 32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_flags", {29'b0, out_overflow, out_inexact, out_underflow}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        send(0, 8'd127, 25'h1000000, 3'b000, mk(32'h40000000, 0, 0, 0, 3));
        send(0, 8'd127, 25'h0200000, 3'b000, mk(32'h3E800000, 0, 0, 0, 5));
        send(0, 8'd1,   25'h0400000, 3'b000, mk(32'h00400000, 0, 0, 0, 3));
        send(0, 8'd127, 25'h0FFFFFF, 3'b100, mk(32'h40000000, 0, 1, 0, 3));
        send(0, 8'd254, 25'h1000000, 3'b000, mk(32'h7F800000, 1, 0, 0, 3));
        send(1, 8'd100, 25'h0000000, 3'b000, mk(32'h80000000, 0, 0, 0, 2));
        send(0, 8'd0,   25'h0000003, 3'b110, mk(32'h00000004, 0, 1, 1, 3));
        wait_idle();

        // Backpressure: result must stay frozen and new input must be ignored.
        hold = 1'b1;
        send(0, 8'd127, 25'h1000000, 3'b000, mk(32'h40000000, 0, 0, 0, 3));
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("bp_valid", 32'(out_valid), 32'd1);
        held = out;
        in_valid = 1'b1; in_mantissa = 25'h0000001; in_exponent = 8'd200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_word", out, held);
            check("bp_valid_held", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        hold = 1'b0;
        wait_idle();

        // Reset in the middle of a long normalization run.
        send(0, 8'd127, 25'h0000001, 3'b000, model(0, 127, 25'h0000001, 3'b000));
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_out", out, 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        if (q.size() > 0) q.delete(q.size() - 1);
        @(negedge clk);
        reset = 1'b0;
        send(0, 8'd127, 25'h0200000, 3'b000, mk(32'h3E800000, 0, 0, 0, 5));
        wait_idle();

        for (int t = 0; t < 250; t++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                0: e = 8'($urandom_range(250, 255));
                1: e = 8'($urandom_range(0, 3));
                default: e = 8'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 3))
                0: m = 25'($urandom);
                1: m = 25'($urandom >> $urandom_range(8, 31));
                2: m = {2'b01, 23'($urandom)};
                default: m = 25'h0FFFFFF;
            endcase
            g = 3'($urandom);
            send(s, e, m, g, model(s, int'(e), m, g));
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
